// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS-subset controller.
// Holds state encoding, opcode/funct fields, and ALU function codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_LOGIEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    AOP_ADD,
    AOP_SUB,
    AOP_FUNCT,
    AOP_AND,
    AOP_OR
  } alu_op_t;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// selects/enables/ALU code out. imm_zext exists only with MC_IMM_LOGIC_EN.
interface mc_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [2:0] alu_control;
  logic       illegal_op;
`ifdef MC_IMM_LOGIC_EN
  logic       imm_zext;
`endif

  modport master (
    input  opcode, funct, zero,
`ifdef MC_IMM_LOGIC_EN
    output imm_zext,
`endif
    output pc_en, iord, mem_write, ir_write,
    output reg_dst, mem_to_reg, reg_write,
    output alu_src_a, alu_src_b, pc_src,
    output alu_control, illegal_op
  );

  modport slave (
    output opcode, funct, zero,
`ifdef MC_IMM_LOGIC_EN
    input  imm_zext,
`endif
    input  pc_en, iord, mem_write, ir_write,
    input  reg_dst, mem_to_reg, reg_write,
    input  alu_src_a, alu_src_b, pc_src,
    input  alu_control, illegal_op
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps an ALU operation class (plus funct for R-type) to the 3-bit ALU F.
// Ports: alu_op, funct in; alu_control, bad_funct out.
module alu_decoder
  import mc_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       bad_funct
);

  always_comb begin
    alu_control = ALU_ADD;
    bad_funct   = 1'b0;
    unique case (alu_op)
      AOP_ADD: alu_control = ALU_ADD;
      AOP_SUB: alu_control = ALU_SUB;
      AOP_AND: alu_control = ALU_AND;
      AOP_OR:  alu_control = ALU_OR;
      AOP_FUNCT: begin
        unique case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: bad_funct   = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM (Moore; alu_control also sees funct).
// Ports: clk, reset (async high), bus (mc_if.master). Option: MC_IMM_LOGIC_EN.
module mc_controller
  import mc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mc_if.master bus
);

  state_t     state, next;
  alu_op_t    alu_op;
  logic       op_bad, bad_funct;
  logic       pc_write, branch;
  logic       mw, irw, rw, zext;
  logic [2:0] alu_ctl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  always_comb begin
    next   = S_FETCH;
    op_bad = 1'b0;
    case (state)
      S_FETCH: next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: next = S_MEMADR;
          OP_RTYPE:     next = S_EXECUTE;
          OP_BEQ:       next = S_BRANCH;
          OP_ADDI:      next = S_ADDIEX;
          OP_J:         next = S_JUMP;
`ifdef MC_IMM_LOGIC_EN
          OP_ANDI, OP_ORI: next = S_LOGIEX;
`endif
          default:      op_bad = 1'b1;
        endcase
      end
      S_MEMADR:
        next = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: next = S_MEMWB;
      S_EXECUTE: next = S_ALUWB;
      S_ADDIEX:  next = S_ADDIWB;
`ifdef MC_IMM_LOGIC_EN
      S_LOGIEX:  next = S_ADDIWB;
`endif
      default:   next = S_FETCH;
    endcase
  end

  always_comb begin
    bus.iord       = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.pc_src     = 2'b00;
    alu_op         = AOP_AND;
    pc_write       = 1'b0;
    branch         = 1'b0;
    mw             = 1'b0;
    irw            = 1'b0;
    rw             = 1'b0;
    zext           = 1'b0;
    case (state)
      S_FETCH: begin
        bus.alu_src_b = 2'b01;
        alu_op        = AOP_ADD;
        irw           = 1'b1;
        pc_write      = 1'b1;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        alu_op        = AOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        alu_op        = AOP_ADD;
      end
      S_MEMREAD: bus.iord = 1'b1;
      S_MEMWB: begin
        bus.mem_to_reg = 1'b1;
        rw             = 1'b1;
      end
      S_MEMWRITE: begin
        bus.iord = 1'b1;
        mw       = 1'b1;
      end
      S_EXECUTE: begin
        bus.alu_src_a = 1'b1;
        alu_op        = AOP_FUNCT;
      end
      S_ALUWB: begin
        bus.reg_dst = 1'b1;
        rw          = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.pc_src    = 2'b01;
        alu_op        = AOP_SUB;
        branch        = 1'b1;
      end
      S_ADDIWB: rw = 1'b1;
      S_JUMP: begin
        bus.pc_src = 2'b10;
        pc_write   = 1'b1;
      end
`ifdef MC_IMM_LOGIC_EN
      S_LOGIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        alu_op = (bus.opcode == OP_ORI) ? AOP_OR : AOP_AND;
        zext   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct       (bus.funct),
    .alu_control (alu_ctl),
    .bad_funct   (bad_funct)
  );

  assign bus.alu_control = alu_ctl;
  assign bus.illegal_op  = op_bad | bad_funct;

  // Enables are gated by reset itself so nothing can pulse
  // while reset is held, even before the state register settles.
  assign bus.pc_en     = (pc_write | (branch & bus.zero)) & ~reset;
  assign bus.mem_write = mw  & ~reset;
  assign bus.ir_write  = irw & ~reset;
  assign bus.reg_write = rw  & ~reset;

`ifdef MC_IMM_LOGIC_EN
  assign bus.imm_zext = zext;
`else
  logic unused_zext;
  assign unused_zext = zext;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected output vectors
// are queued per instruction and compared at the falling edge.
module tb_mc_controller;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  mc_if m ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [16:0] obs;
  logic        iz_obs;
`ifdef MC_IMM_LOGIC_EN
  assign iz_obs = m.imm_zext;
`else
  assign iz_obs = 1'b0;
`endif
  assign obs = {iz_obs, m.pc_en, m.iord, m.mem_write, m.ir_write,
                m.reg_dst, m.mem_to_reg, m.reg_write, m.alu_src_a,
                m.alu_src_b, m.pc_src, m.alu_control, m.illegal_op};

  function automatic logic [16:0] mk(
    bit pe, bit io, bit mw, bit irw, bit rd, bit m2r, bit rw,
    bit sa, logic [1:0] sb, logic [1:0] ps, logic [2:0] ac,
    bit ill, bit iz);
    return {iz, pe, io, mw, irw, rd, m2r, rw, sa, sb, ps, ac, ill};
  endfunction

  task automatic chk(string tag, logic [16:0] got, logic [16:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] v_f();
    return mk(1,0,0,1,0,0,0,0,2'b01,2'b00,3'b010,0,0);
  endfunction
  function automatic logic [16:0] v_rst();
    return mk(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0);
  endfunction
  function automatic logic [16:0] v_d(bit ill);
    return mk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,ill,0);
  endfunction
  function automatic logic [16:0] v_ma();
    return mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0);
  endfunction
  function automatic logic [16:0] v_mr();
    return mk(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0);
  endfunction
  function automatic logic [16:0] v_mwb();
    return mk(0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0,0);
  endfunction
  function automatic logic [16:0] v_mw();
    return mk(0,1,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,0);
  endfunction
  function automatic logic [16:0] v_ex(logic [2:0] ac, bit ill);
    return mk(0,0,0,0,0,0,0,1,2'b00,2'b00,ac,ill,0);
  endfunction
  function automatic logic [16:0] v_awb();
    return mk(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,0);
  endfunction
  function automatic logic [16:0] v_br(bit z);
    return mk(z,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,0);
  endfunction
  function automatic logic [16:0] v_iwb();
    return mk(0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0,0);
  endfunction
  function automatic logic [16:0] v_j();
    return mk(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0,0);
  endfunction
  function automatic logic [16:0] v_lx(logic [2:0] ac);
    return mk(0,0,0,0,0,0,0,1,2'b10,2'b00,ac,0,1);
  endfunction

  task automatic push(string tag, logic [16:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb_q.push_back(e);
  endtask

  // Entered #1 after a rising edge; returns #1 after a rising edge.
  task automatic run(logic [5:0] op, logic [5:0] fn, logic z);
    exp_t e;
    m.opcode = op;
    m.funct  = fn;
    m.zero   = z;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      chk(e.tag, obs, e.v);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset    = 1'b1;
    m.opcode = OP_LW;
    m.funct  = 6'b0;
    m.zero   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", obs, v_rst());
    end
    @(posedge clk);
    #1 reset = 1'b0;

    push("lw_f", v_f()); push("lw_d", v_d(0)); push("lw_ma", v_ma());
    push("lw_mr", v_mr()); push("lw_wb", v_mwb());
    run(OP_LW, 6'b0, 1'b1);

    push("sw_f", v_f()); push("sw_d", v_d(0)); push("sw_ma", v_ma());
    push("sw_mw", v_mw());
    run(OP_SW, 6'b0, 1'b1);

    push("slt_f", v_f()); push("slt_d", v_d(0));
    push("slt_ex", v_ex(3'b111, 0)); push("slt_wb", v_awb());
    run(OP_RTYPE, FN_SLT, 1'b1);

    push("sub_f", v_f()); push("sub_d", v_d(0));
    push("sub_ex", v_ex(3'b110, 0)); push("sub_wb", v_awb());
    run(OP_RTYPE, FN_SUB, 1'b1);

    push("and_f", v_f()); push("and_d", v_d(0));
    push("and_ex", v_ex(3'b000, 0)); push("and_wb", v_awb());
    run(OP_RTYPE, FN_AND, 1'b1);

    push("or_f", v_f()); push("or_d", v_d(0));
    push("or_ex", v_ex(3'b001, 0)); push("or_wb", v_awb());
    run(OP_RTYPE, FN_OR, 1'b1);

    push("add_f", v_f()); push("add_d", v_d(0));
    push("add_ex", v_ex(3'b010, 0)); push("add_wb", v_awb());
    run(OP_RTYPE, FN_ADD, 1'b1);

    push("badfn_f", v_f()); push("badfn_d", v_d(0));
    push("badfn_ex", v_ex(3'b010, 1)); push("badfn_wb", v_awb());
    run(OP_RTYPE, 6'b000111, 1'b1);

    push("beq1_f", v_f()); push("beq1_d", v_d(0)); push("beq1_br", v_br(1));
    run(OP_BEQ, 6'b0, 1'b1);

    push("beq0_f", v_f()); push("beq0_d", v_d(0)); push("beq0_br", v_br(0));
    run(OP_BEQ, 6'b0, 1'b0);

    push("addi_f", v_f()); push("addi_d", v_d(0));
    push("addi_ex", v_ma()); push("addi_wb", v_iwb());
    run(OP_ADDI, 6'b0, 1'b1);

    push("j_f", v_f()); push("j_d", v_d(0)); push("j_j", v_j());
    run(OP_J, 6'b0, 1'b1);

    push("ill_f", v_f()); push("ill_d", v_d(1));
    run(6'b111111, 6'b0, 1'b1);

`ifdef MC_IMM_LOGIC_EN
    push("ori_f", v_f()); push("ori_d", v_d(0));
    push("ori_ex", v_lx(3'b001)); push("ori_wb", v_iwb());
    run(OP_ORI, 6'b0, 1'b1);
    push("andi_f", v_f()); push("andi_d", v_d(0));
    push("andi_ex", v_lx(3'b000)); push("andi_wb", v_iwb());
    run(OP_ANDI, 6'b0, 1'b1);
`else
    push("ori_f", v_f()); push("ori_d", v_d(1));
    run(OP_ORI, 6'b0, 1'b1);
    push("andi_f", v_f()); push("andi_d", v_d(1));
    run(OP_ANDI, 6'b0, 1'b1);
`endif

    push("abort_f", v_f()); push("abort_d", v_d(0));
    push("abort_ma", v_ma());
    run(OP_SW, 6'b0, 1'b1);
    #2 chk("abort_mw_pre", obs, v_mw());
    reset = 1'b1;
    #1 chk("abort_mw_drop", obs, v_rst());
    @(posedge clk);
    @(negedge clk);
    chk("abort_hold", obs, v_rst());
    @(posedge clk);
    #1 reset = 1'b0;

    push("post_f", v_f()); push("post_d", v_d(0)); push("post_j", v_j());
    run(OP_J, 6'b0, 1'b1);
    push("final_f", v_f());
    run(OP_LW, 6'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
